// File: rtl/spi_cmd_arbiter.sv
// Arbitrates the radio SPI command channel among init, RX and TX requesters.
// One owner holds the channel for a whole transaction, followed by a one-cycle release gap.
module spi_cmd_arbiter #(
   parameter logic [15:0] TIMEOUT = 16'd4096,
   parameter int          TW      = 16
) (
   input  logic       Clock,
   input  logic       Reset,
   input  logic       InitDone,
   input  logic [2:0] Req,
   input  logic [2:0] Valid,
   input  logic [2:0] Last,
   input  logic [7:0] Data0,
   input  logic [7:0] Data1,
   input  logic [7:0] Data2,
   input  logic       InRequest,
   input  logic [7:0] SO,
   output logic [7:0] Command,
   output logic       InValid,
   output logic [2:0] Grant,
   output logic [2:0] Ack,
   output logic [7:0] Status,
   output logic       Timeout,
   output logic       Abort,
   output logic       Busy
);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_OWN     = 2'd1,
      ST_RELEASE = 2'd2
   } state_t;

   localparam logic [TW-1:0] CNT_LAST = TW'(TIMEOUT - 16'd1);
   localparam logic [TW-1:0] CNT_MAX  = {TW{1'b1}};

   state_t        state_q, state_d;
   logic [2:0]    grant_q, grant_d;
   logic [1:0]    rr_last_q, rr_last_d;
   logic [TW-1:0] count_q, count_d;
   logic [7:0]    status_q, status_d;
   logic          timeout_q, timeout_d;
   logic          abort_q, abort_d;

   logic [7:0]    own_data_s;
   logic          own_valid_s;
   logic          own_req_s;
   logic          own_last_s;
   logic          accept_s;
   logic [2:0]    elig_s;
   logic [2:0]    win_s;

   // Owner-side mux and byte handshake toward the SPI engine.
   always_comb begin
      own_data_s  = 8'h00;
      own_valid_s = 1'b0;
      own_req_s   = 1'b0;
      own_last_s  = 1'b0;
      case (grant_q)
         3'b001: begin
            own_data_s = Data0; own_valid_s = Valid[0]; own_req_s = Req[0]; own_last_s = Last[0];
         end
         3'b010: begin
            own_data_s = Data1; own_valid_s = Valid[1]; own_req_s = Req[1]; own_last_s = Last[1];
         end
         3'b100: begin
            own_data_s = Data2; own_valid_s = Valid[2]; own_req_s = Req[2]; own_last_s = Last[2];
         end
         default: begin
            own_data_s = 8'h00; own_valid_s = 1'b0; own_req_s = 1'b0; own_last_s = 1'b0;
         end
      endcase
      accept_s = own_valid_s & InRequest;
      Command  = 8'h00;
      InValid  = 1'b0;
      Ack      = 3'b000;
      // A byte presented while Reset is high is never acknowledged.
      if ((state_q == ST_OWN) && !Reset) begin
         Command = own_data_s;
         InValid = own_valid_s;
         Ack     = grant_q & {3{accept_s}};
      end else begin
         Command = 8'h00;
         InValid = 1'b0;
         Ack     = 3'b000;
      end
   end

   // Eligibility and round-robin winner selection.
   always_comb begin
      elig_s = InitDone ? {Req[2:1], 1'b0} : {2'b00, Req[0]};
      win_s  = 3'b000;
      if (elig_s[0]) begin
         win_s = 3'b001;
      end else if (elig_s[1] && elig_s[2]) begin
         win_s = (rr_last_q == 2'd1) ? 3'b100 : 3'b010;
      end else if (elig_s[1]) begin
         win_s = 3'b010;
      end else if (elig_s[2]) begin
         win_s = 3'b100;
      end else begin
         win_s = 3'b000;
      end
   end

   // Next-state logic: grant, watchdog, completion, abort.
   always_comb begin
      state_d   = state_q;
      grant_d   = grant_q;
      rr_last_d = rr_last_q;
      count_d   = count_q;
      status_d  = status_q;
      timeout_d = 1'b0;
      abort_d   = 1'b0;
      case (state_q)
         ST_IDLE: begin
            count_d = {TW{1'b0}};
            if (win_s != 3'b000) begin
               grant_d = win_s;
               state_d = ST_OWN;
               if (win_s[1]) begin
                  rr_last_d = 2'd1;
               end else if (win_s[2]) begin
                  rr_last_d = 2'd2;
               end else begin
                  rr_last_d = rr_last_q;
               end
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_OWN: begin
            // An accepted byte outranks both abort and watchdog expiry.
            if (accept_s) begin
               status_d = SO;
               count_d  = {TW{1'b0}};
               if (own_last_s) begin
                  state_d = ST_RELEASE;
                  grant_d = 3'b000;
               end else begin
                  state_d = ST_OWN;
               end
            end else if (!own_req_s) begin
               abort_d = 1'b1;
               state_d = ST_RELEASE;
               grant_d = 3'b000;
               count_d = {TW{1'b0}};
            end else if (count_q == CNT_LAST) begin
               timeout_d = 1'b1;
               state_d   = ST_RELEASE;
               grant_d   = 3'b000;
               count_d   = {TW{1'b0}};
            end else begin
               count_d = (count_q == CNT_MAX) ? count_q : count_q + TW'(1);
            end
         end
         ST_RELEASE: begin
            grant_d = 3'b000;
            count_d = {TW{1'b0}};
            state_d = ST_IDLE;
         end
         default: begin
            grant_d = 3'b000;
            count_d = {TW{1'b0}};
            state_d = ST_IDLE;
         end
      endcase
   end

   // State and registered-output flops.
   always_ff @(posedge Clock) begin
      if (Reset) begin
         state_q   <= ST_IDLE;
         grant_q   <= 3'b000;
         rr_last_q <= 2'd2;
         count_q   <= {TW{1'b0}};
         status_q  <= 8'h00;
         timeout_q <= 1'b0;
         abort_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         grant_q   <= grant_d;
         rr_last_q <= rr_last_d;
         count_q   <= count_d;
         status_q  <= status_d;
         timeout_q <= timeout_d;
         abort_q   <= abort_d;
      end
   end

   assign Grant   = grant_q;
   assign Status  = status_q;
   assign Timeout = timeout_q;
   assign Abort   = abort_q;
   assign Busy    = (state_q != ST_IDLE);

endmodule

// File: tb/tb_spi_cmd_arbiter.sv
// Bench for spi_cmd_arbiter: directed scenarios with literal expectations,
// then random traffic, all compared every cycle against a transaction-level model.
module tb_spi_cmd_arbiter;

   localparam logic [15:0] TMO = 16'd16;

   logic       Clock = 1'b0;
   logic       Reset, InitDone, InRequest;
   logic [2:0] Req, Valid, Last;
   logic [7:0] Data0, Data1, Data2, SO;
   logic [7:0] Command, Status;
   logic       InValid, Timeout, Abort, Busy;
   logic [2:0] Grant, Ack;

   spi_cmd_arbiter #(.TIMEOUT(TMO), .TW(16)) dut (
      .Clock(Clock), .Reset(Reset), .InitDone(InitDone), .Req(Req), .Valid(Valid),
      .Last(Last), .Data0(Data0), .Data1(Data1), .Data2(Data2), .InRequest(InRequest),
      .SO(SO), .Command(Command), .InValid(InValid), .Grant(Grant), .Ack(Ack),
      .Status(Status), .Timeout(Timeout), .Abort(Abort), .Busy(Busy)
   );

   always #5 Clock = ~Clock;

   int n_checks = 0;
   int n_errs   = 0;
   int cyc      = 0;

   always @(posedge Clock) cyc++;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errs++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic tick();
      @(posedge Clock);
      #1;
   endtask

   // Transaction-level model: who owns the channel, whether a release gap is
   // pending, idle cycles since the last accepted byte, and the pulse flags.
   int         m_owner  = -1;
   bit         m_rel    = 1'b0;
   int         m_idle   = 0;
   int         m_rr     = 2;
   logic [7:0] m_status = 8'h00;
   bit         m_tmo    = 1'b0;
   bit         m_abt    = 1'b0;
   int         m_w;
   logic [7:0] md [3];
   logic [2:0] e_grant, e_ack;
   logic [7:0] e_cmd;
   logic       e_iv, own_on;

   always @(negedge Clock) begin
      if (cyc >= 1) begin
         md[0] = Data0; md[1] = Data1; md[2] = Data2;
         e_grant = (m_owner >= 0) ? (3'b001 << m_owner) : 3'b000;
         own_on  = (m_owner >= 0) && !Reset;
         e_cmd   = own_on ? md[m_owner] : 8'h00;
         e_iv    = own_on ? Valid[m_owner] : 1'b0;
         e_ack   = (own_on && Valid[m_owner] && InRequest) ? e_grant : 3'b000;
         chk("m_grant",   32'(Grant),   32'(e_grant));
         chk("m_command", 32'(Command), 32'(e_cmd));
         chk("m_invalid", 32'(InValid), 32'(e_iv));
         chk("m_ack",     32'(Ack),     32'(e_ack));
         chk("m_status",  32'(Status),  32'(m_status));
         chk("m_timeout", 32'(Timeout), 32'(m_tmo));
         chk("m_abort",   32'(Abort),   32'(m_abt));
         chk("m_busy",    32'(Busy),    32'(m_owner >= 0 || m_rel));
      end
      // Advance the model with the inputs that the coming rising edge samples.
      if (Reset) begin
         m_owner = -1; m_rel = 1'b0; m_idle = 0; m_rr = 2;
         m_status = 8'h00; m_tmo = 1'b0; m_abt = 1'b0;
      end else begin
         m_tmo = 1'b0;
         m_abt = 1'b0;
         if (m_rel) begin
            m_rel = 1'b0;
         end else if (m_owner < 0) begin
            m_w = -1;
            if (!InitDone) begin
               if (Req[0]) m_w = 0;
            end else if (Req[1] && Req[2]) begin
               m_w = (m_rr == 1) ? 2 : 1;
            end else if (Req[1]) begin
               m_w = 1;
            end else if (Req[2]) begin
               m_w = 2;
            end
            if (m_w >= 0) begin
               m_owner = m_w;
               m_idle  = 0;
               if (m_w != 0) m_rr = m_w;
            end
         end else if (Valid[m_owner] && InRequest) begin
            m_status = SO;
            m_idle   = 0;
            if (Last[m_owner]) begin
               m_owner = -1; m_rel = 1'b1;
            end
         end else if (!Req[m_owner]) begin
            m_abt = 1'b1; m_owner = -1; m_rel = 1'b1;
         end else if (m_idle == int'(TMO) - 1) begin
            m_tmo = 1'b1; m_owner = -1; m_rel = 1'b1;
         end else begin
            m_idle++;
         end
      end
   end

   task automatic wait_grant();
      for (int i = 0; i < 8; i++) begin
         if (Grant != 3'b000) return;
         tick();
      end
      if (Grant == 3'b000) begin
         n_checks++;
         n_errs++;
         $display("FAIL grant_wait: got Grant 000 expected a grant within 8 cycles (cycle %0d)", cyc);
      end
   endtask

   logic [2:0] rr_exp [4] = '{3'b010, 3'b100, 3'b010, 3'b100};
   logic [2:0] rq;
   bit         quiet;

   initial begin
      Reset = 1'b1; InitDone = 1'b0; InRequest = 1'b0;
      Req = 3'b000; Valid = 3'b000; Last = 3'b000;
      Data0 = 8'h00; Data1 = 8'h00; Data2 = 8'h00; SO = 8'h00;
      tick(); tick();
      chk("rst_grant",  32'(Grant),  32'h0);
      chk("rst_status", 32'(Status), 32'h0);
      chk("rst_busy",   32'(Busy),   32'h0);

      // Init phase: only requester 0 may win.
      Reset = 1'b0; Req = 3'b111; Data1 = 8'hA1; Data2 = 8'hA2;
      tick();
      chk("init_grant", 32'(Grant), 32'h1);
      Valid = 3'b001; Last = 3'b001; Data0 = 8'h01; InRequest = 1'b1; Req = 3'b000;
      #1;
      chk("init_cmd", 32'(Command), 32'h01);
      chk("init_ack", 32'(Ack),     32'h1);
      tick();
      chk("init_rel_grant", 32'(Grant), 32'h0);
      chk("init_rel_busy",  32'(Busy),  32'h1);
      Valid = 3'b000; Last = 3'b000; InRequest = 1'b0;
      tick();
      chk("init_idle_busy", 32'(Busy), 32'h0);

      // Round-robin with requester 0 still requesting but ignored.
      InitDone = 1'b1; Req = 3'b111; Valid = 3'b111; InRequest = 1'b1;
      for (int t = 0; t < 4; t++) begin
         wait_grant();
         chk("rr_grant", 32'(Grant), 32'(rr_exp[t]));
         tick();
         tick();
         Last = 3'b111;
         #1;
         chk("rr_ack3", 32'(Ack), 32'(rr_exp[t]));
         tick();
         Last = 3'b000;
         chk("rr_release", 32'(Grant), 32'h0);
      end
      Req = 3'b000; Valid = 3'b000;
      tick(); tick();

      // Multi-byte transaction on requester 1.
      Req = 3'b010; Valid = 3'b010; InRequest = 1'b1; Data1 = 8'h18; SO = 8'h11;
      wait_grant();
      chk("mb_cmd0", 32'(Command), 32'h18);
      chk("mb_ack0", 32'(Ack),     32'h2);
      tick();
      Data1 = 8'h41; SO = 8'h22;
      #1;
      chk("mb_cmd1", 32'(Command), 32'h41);
      tick();
      chk("mb_hold", 32'(Grant), 32'h2);
      Data1 = 8'h97; SO = 8'h46; Last = 3'b010;
      #1;
      chk("mb_ack2", 32'(Ack), 32'h2);
      tick();
      chk("mb_status", 32'(Status), 32'h46);
      chk("mb_rel",    32'(Grant),  32'h0);
      Req = 3'b000; Valid = 3'b000; Last = 3'b000;
      tick(); tick();

      // Watchdog: owner 2 holds Req without presenting bytes.
      Req = 3'b100;
      wait_grant();
      repeat (15) tick();
      chk("wd_pre_tmo",   32'(Timeout), 32'h0);
      chk("wd_pre_grant", 32'(Grant),   32'h4);
      tick();
      chk("wd_tmo",    32'(Timeout), 32'h1);
      chk("wd_grant",  32'(Grant),   32'h0);
      chk("wd_status", 32'(Status),  32'h46);
      Req = 3'b000;
      tick();
      chk("wd_pulse_end", 32'(Timeout), 32'h0);
      tick();

      // Last byte accepted exactly when the watchdog would expire.
      Req = 3'b010; Valid = 3'b000; InRequest = 1'b1;
      wait_grant();
      repeat (15) tick();
      Valid = 3'b010; Last = 3'b010; SO = 8'h5A;
      #1;
      chk("col_ack", 32'(Ack), 32'h2);
      tick();
      chk("col_tmo",    32'(Timeout), 32'h0);
      chk("col_grant",  32'(Grant),   32'h0);
      chk("col_status", 32'(Status),  32'h5A);
      Req = 3'b000; Valid = 3'b000; Last = 3'b000;
      tick(); tick();

      // Abort: owner drops Req after one of three bytes.
      Req = 3'b100; Valid = 3'b100; InRequest = 1'b1; Data2 = 8'h33;
      wait_grant();
      tick();
      Req = 3'b000; InRequest = 1'b0;
      chk("ab_early", 32'(Abort), 32'h0);
      tick();
      chk("ab_pulse", 32'(Abort), 32'h1);
      chk("ab_grant", 32'(Grant), 32'h0);
      Valid = 3'b000;
      tick();
      chk("ab_pulse_end", 32'(Abort), 32'h0);

      // Reset in the middle of a transaction.
      Req = 3'b010; Valid = 3'b010; InRequest = 1'b0; SO = 8'h77;
      wait_grant();
      tick();
      Reset = 1'b1; InRequest = 1'b1;
      #1;
      chk("rst_mid_ack", 32'(Ack), 32'h0);
      tick();
      chk("rst_mid_grant",   32'(Grant),   32'h0);
      chk("rst_mid_invalid", 32'(InValid), 32'h0);
      chk("rst_mid_status",  32'(Status),  32'h0);
      Reset = 1'b0; Req = 3'b000; Valid = 3'b000; InRequest = 1'b0;
      tick();

      // Random traffic, checked by the model every cycle.
      InitDone = 1'b0;
      rq = 3'b000;
      for (int i = 0; i < 3000; i++) begin
         InitDone = (i >= 800);
         for (int r = 0; r < 3; r++) begin
            if (rq[r]) begin
               if ($urandom_range(0, 39) == 0) rq[r] = 1'b0;
            end else begin
               if ($urandom_range(0, 3) == 0) rq[r] = 1'b1;
            end
         end
         Req   = rq;
         quiet = ((i / 60) % 5) == 4;
         Valid = quiet ? 3'b000 : 3'($urandom);
         for (int r = 0; r < 3; r++) Last[r] = ($urandom_range(0, 2) == 0);
         InRequest = ($urandom_range(0, 2) != 0);
         Data0 = 8'($urandom); Data1 = 8'($urandom); Data2 = 8'($urandom);
         SO    = 8'($urandom);
         Reset = ($urandom_range(0, 499) == 0);
         tick();
      end
      Reset = 1'b0; Req = 3'b000; Valid = 3'b000;
      tick(); tick(); tick();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
      $finish;
   end

endmodule
